// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its datapath.
package alu_pkg;

  localparam int unsigned ALU_W  = 6;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CNT_W  = 8;

  // Bit positions inside the {overflow, carry, zero} flag vector
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_AEQB  = 3'd5,
    OP_SLT   = 3'd6,
    OP_PASSA = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Round-robin pick for two requesters: a tie goes to the one not granted last,
  // a lone valid requester always wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last_gnt);
    logic pick;
    if (&valid) pick = ~last_gnt;
    else        pick = valid[1];
    return pick;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 6-bit ALU: (a, b, op) -> (result, {overflow, carry, zero}).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  alu_op_t           op_i,
  output logic [WIDTH-1:0]  res_c,
  output logic [FLAG_W-1:0] flags_c
);

  logic [WIDTH:0] sum_w;
  logic           carry;
  logic           ovf;

  // Opcode decode; carry/overflow only meaningful for ADD/SUB, SUB carry is no-borrow
  always_comb begin
    sum_w   = '0;
    res_c   = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    flags_c = '0;
    case (op_i)
      OP_ADD: begin
        sum_w = {1'b0, a_i} + {1'b0, b_i};
        res_c = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sum_w = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
        res_c = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:   res_c = a_i & b_i;
      OP_OR:    res_c = a_i | b_i;
      OP_XOR:   res_c = a_i ^ b_i;
      OP_AEQB:  res_c = WIDTH'(a_i == b_i);
      OP_SLT:   res_c = WIDTH'($signed(a_i) < $signed(b_i));
      OP_PASSA: res_c = a_i;
      default:  res_c = '0;
    endcase
    flags_c[FLAG_Z] = (res_c == '0);
    flags_c[FLAG_C] = carry;
    flags_c[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core between two valid/ready requesters.
// Optional per-requester saturating grant counters when ALU_ARB_STATS_EN is defined;
// otherwise gnt_cnt reads 0 and the port list is unchanged.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  logic [NREQ-1:0][OP_W-1:0]  req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [WIDTH-1:0]           rsp_c,
  output logic [FLAG_W-1:0]          rsp_flags,
  output logic [NREQ-1:0][CNT_W-1:0] gnt_cnt
);

  arb_state_t        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  alu_op_t           op_q, op_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_c_q, rsp_c_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

  logic              any_valid_c;
  logic              gnt_id_c;
  logic [WIDTH-1:0]  alu_res_c;
  logic [FLAG_W-1:0] alu_flags_c;

  // Grant selection depends only on req_valid and the last grant
  always_comb begin
    any_valid_c = |req_valid;
    gnt_id_c    = rr_pick(req_valid, last_gnt_q);
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .res_c   (alu_res_c),
    .flags_c (alu_flags_c)
  );

  // Next-state, operand latch and response capture
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    rsp_flags_d = rsp_flags_q;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          // The granted requester is valid by construction, so ready implies handshake
          req_ready[gnt_id_c] = 1'b1;
          a_d        = req_a[gnt_id_c];
          b_d        = req_b[gnt_id_c];
          op_d       = alu_op_t'(req_op[gnt_id_c]);
          id_d       = gnt_id_c;
          last_gnt_d = gnt_id_c;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_c_d     = alu_res_c;
        rsp_flags_d = alu_flags_c;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_c_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_flags = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NREQ-1:0][CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

  // Saturating count of accepted requests per requester
  always_comb begin
    gnt_cnt_d = gnt_cnt_q;
    if ((state_q == ST_IDLE) && any_valid_c && (gnt_cnt_q[gnt_id_c] != CNT_MAX)) begin
      gnt_cnt_d[gnt_id_c] = gnt_cnt_q[gnt_id_c] + CNT_W'(1);
    end
  end

  // Grant counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gnt_cnt_q <= '0;
    else        gnt_cnt_q <= gnt_cnt_d;
  end

  assign gnt_cnt = gnt_cnt_q;
`else
  assign gnt_cnt = '0;
`endif

endmodule
